// File: rtl/neuro_uart_link.sv
// neuro_uart_link: full-duplex UART between the NeuralChip core and tile pins.
// RX path: 2-flop synchroniser, RX FSM, show-ahead FIFO, framing/overrun pulses.
// TX path: valid/ready capture into a word register, then start/data/stop bits.
// Optional even parity on both directions: define NEURO_UART_PARITY_EN.
module neuro_uart_link #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RXD,
    output logic                 TXD,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 rx_overrun
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef NEURO_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    // ---------------- RX synchroniser ----------------
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // ---------------- RX FSM ----------------
    state_e               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_err_q, rx_par_err_d;
    logic                 rx_push, rx_bad;

    // RX next-state: mid-bit sampling driven by a down-counter per bit period.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_err_d = rx_par_err_q;
        rx_push      = 1'b0;
        rx_bad       = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_state_d   = S_START;
                    rx_cnt_d     = CNT_HALF;
                    rx_par_err_d = 1'b0;
                end
            end
            S_START: begin
                if (rx_cnt_q == '0) begin
                    // A line that is high again at mid-start was only a glitch.
                    rx_state_d = rxd_sync_q ? S_IDLE : S_DATA;
                    rx_cnt_d   = CNT_FULL;
                    rx_bit_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_cnt_d   = CNT_FULL;
                    if (rx_bit_q == BIT_LAST) begin
`ifdef NEURO_UART_PARITY_EN
                        rx_state_d = S_PARITY;
`else
                        rx_state_d = S_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
`ifdef NEURO_UART_PARITY_EN
            S_PARITY: begin
                if (rx_cnt_q == '0) begin
                    rx_par_err_d = rxd_sync_q != (^rx_shift_q);
                    rx_state_d   = S_STOP;
                    rx_cnt_d     = CNT_FULL;
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = S_IDLE;
                    if (rxd_sync_q && !rx_par_err_q) rx_push = 1'b1;
                    else                             rx_bad  = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_err_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_err_q <= rx_par_err_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 fifo_full, fifo_wr, fifo_rd;
    logic                 frame_err_q, rx_overrun_q;

    assign rx_valid  = (wr_ptr_q != rd_ptr_q);
    assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_rd   = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign fifo_wr   = rx_push && (!fifo_full || fifo_rd);
    assign rx_data   = rx_valid ? fifo_mem_q[rd_ptr_q[AW-1:0]] : '0;

    // FIFO storage write.
    always_ff @(posedge CLK) begin
        // NOTE: storage has no reset; pointers define validity and rx_data is masked while empty.
        if (fifo_wr) fifo_mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end

    // FIFO pointers and one-cycle error pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_err_q  <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            frame_err_q  <= rx_bad;
            rx_overrun_q <= rx_push && !fifo_wr;
        end
    end

    assign frame_err  = frame_err_q;
    assign rx_overrun = rx_overrun_q;

    // ---------------- TX FSM ----------------
    state_e               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_word_q, tx_word_d;
    logic                 txd_q, txd_d;

    assign tx_ready = (tx_state_q == S_IDLE);
    assign TXD      = txd_q;

    // TX next-state: each bit is held for CLK_DIV cycles; TXD is registered.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_word_d  = tx_word_q;
        txd_d      = txd_q;
        case (tx_state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (tx_valid) begin
                    tx_word_d  = tx_data;
                    tx_state_d = S_START;
                    tx_cnt_d   = CNT_FULL;
                    txd_d      = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = CNT_FULL;
                    tx_bit_d   = '0;
                    txd_d      = tx_word_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = CNT_FULL;
                    if (tx_bit_q == BIT_LAST) begin
`ifdef NEURO_UART_PARITY_EN
                        tx_state_d = S_PARITY;
                        txd_d      = ^tx_word_q;
`else
                        tx_state_d = S_STOP;
                        txd_d      = 1'b1;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + BW'(1);
                        txd_d    = tx_word_q[tx_bit_d];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
`ifdef NEURO_UART_PARITY_EN
            S_PARITY: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_STOP;
                    tx_cnt_d   = CNT_FULL;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_IDLE;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    // TX state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_word_q  <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_word_q  <= tx_word_d;
            txd_q      <= txd_d;
        end
    end
endmodule

// File: tb/tb_neuro_uart_link.sv
// Self-checking bench for neuro_uart_link: randomized words against a queue-based model.
module tb_neuro_uart_link;
    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
`ifdef NEURO_UART_PARITY_EN
    localparam int FRAME_LEN = DATA_BITS + 3;
    localparam int PAR_IDX   = DATA_BITS + 1;
`else
    localparam int FRAME_LEN = DATA_BITS + 2;
    localparam int PAR_IDX   = -1;
`endif

    logic       clk;
    logic       reset;
    logic       rxd_tb, loop_en, rxd_dut, txd;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, frame_err, rx_overrun;

    logic       rxd16, txd16, tx_valid16, tx_ready16, rx_valid16, rx_ready16, fe16, ovr16;
    logic [7:0] tx_data16, rx_data16;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, ovr_cnt = 0, fe16_cnt = 0, ovr16_cnt = 0;

    // Reference model: received words still in the FIFO, and expected pulse totals.
    logic [7:0] exp_q[$];
    int exp_fe  = 0;
    int exp_ovr = 0;

    assign rxd_dut = loop_en ? txd : rxd_tb;

    neuro_uart_link #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK(clk), .RESET(reset), .RXD(rxd_dut), .TXD(txd),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .rx_overrun(rx_overrun)
    );

    neuro_uart_link #(.CLK_DIV(16), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut16 (
        .CLK(clk), .RESET(reset), .RXD(rxd16), .TXD(txd16),
        .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .rx_ready(rx_ready16),
        .frame_err(fe16), .rx_overrun(ovr16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of the pulse outputs, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1)  fe_cnt++;
        if (rx_overrun === 1'b1) ovr_cnt++;
        if (fe16 === 1'b1)       fe16_cnt++;
        if (ovr16 === 1'b1)      ovr16_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line level of frame bit idx: start, data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DATA_BITS) return d[idx-1];
        if (idx == PAR_IDX) return ^d;
        return 1'b1;
    endfunction

    task automatic tx_send(input logic [7:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_send_timeout: tx_ready=%b required 1", tx_ready);
        end
        step(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic check_tx_frame(input logic [7:0] d);
        logic e;
        for (int k = 0; k < FRAME_LEN * CLK_DIV; k++) begin
            e = frame_bit(d, k / CLK_DIV);
            checks++;
            if (txd !== e || tx_ready !== 1'b0) begin
                errors++;
                $display("FAIL tx_bit word=%h cyc=%0d: TXD=%b tx_ready=%b required TXD=%b tx_ready=0",
                         d, k, txd, tx_ready, e);
            end
            step(1);
        end
    endtask

    // Drive one serial frame onto RXD, record the expected outcome, then idle high.
    task automatic rx_frame(input logic [7:0] d, input logic stop_b, input logic par_bad);
        if (!stop_b || (par_bad && PAR_IDX >= 0)) exp_fe++;
        else if (exp_q.size() < FIFO_DEPTH)       exp_q.push_back(d);
        else                                       exp_ovr++;
        for (int i = 0; i < FRAME_LEN; i++) begin
            rxd_tb = (i == FRAME_LEN - 1) ? stop_b : frame_bit(d, i);
            if (par_bad && i == PAR_IDX) rxd_tb = ~rxd_tb;
            step(CLK_DIV);
        end
        rxd_tb = 1'b1;
        step(3 * CLK_DIV);
    endtask

    task automatic check_flags(input string name);
        checks++;
        if (fe_cnt !== exp_fe || ovr_cnt !== exp_ovr) begin
            errors++;
            $display("FAIL %s: frame_err cycles=%0d overrun cycles=%0d required %0d/%0d",
                     name, fe_cnt, ovr_cnt, exp_fe, exp_ovr);
        end
    endtask

    task automatic pop_and_check(input string name);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            if (rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s: rx_valid=%b required 0", name, rx_valid);
            end
        end else begin
            e = exp_q.pop_front();
            if (rx_valid !== 1'b1 || rx_data !== e) begin
                errors++;
                $display("FAIL %s: rx_valid=%b rx_data=%h required 1/%h", name, rx_valid, rx_data, e);
            end
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) pop_and_check(name);
        pop_and_check(name);
    endtask

    task automatic test_reset();
        tx_send(8'($urandom));
        step(10);
        reset = 1'b1;
        step(1);
        checks++;
        if (txd !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: TXD=%b tx_ready=%b required 1/1", txd, tx_ready);
        end
        step(2);
        reset = 1'b0;
        checks++;
        if (txd !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00 ||
            frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: TXD=%b rdy=%b rxv=%b rxd=%h fe=%b ovr=%b required 1 1 0 00 0 0",
                     txd, tx_ready, rx_valid, rx_data, frame_err, rx_overrun);
        end
        step(1);
        checks++;
        if (txd !== 1'b1 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: TXD=%b tx_ready=%b required 1/1", txd, tx_ready);
        end
    endtask

    task automatic test_tx_frame();
        logic [7:0] d;
        for (int w = 0; w < 4; w++) begin
            d = (w == 0) ? 8'hA5 : 8'($urandom);
            tx_send(d);
            check_tx_frame(d);
            checks++;
            if (tx_ready !== 1'b1 || txd !== 1'b1) begin
                errors++;
                $display("FAIL tx_end word=%h: tx_ready=%b TXD=%b required 1/1", d, tx_ready, txd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0, d1;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        tx_data  = d0;
        tx_valid = 1'b1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: tx_ready=%b required 1", tx_ready);
        end
        step(1);
        tx_data = d1;
        check_tx_frame(d0);
        checks++;
        if (tx_ready !== 1'b1 || txd !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: tx_ready=%b TXD=%b required 1/1", tx_ready, txd);
        end
        step(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check_tx_frame(d1);
    endtask

    task automatic test_loopback();
        int n;
        logic [7:0] d;
        loop_en = 1'b1;
        exp_q.push_back(8'h3C);
        tx_send(8'h3C);
        n = 0;
        while (rx_valid !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        checks++;
        if (n !== 2 + CLK_DIV / 2 + (FRAME_LEN - 1) * CLK_DIV + 1 || rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL loop_latency: cycles=%0d rx_data=%h required %0d/3c",
                     n, rx_data, 2 + CLK_DIV / 2 + (FRAME_LEN - 1) * CLK_DIV + 1);
        end
        exp_q.push_back(8'hC3);
        tx_send(8'hC3);
        step(60);
        drain("loop_pop");
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            tx_send(d);
        end
        step(60);
        drain("loop_rand");
        check_flags("loop_flags");
        loop_en = 1'b0;
        step(2);
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) begin
            rx_frame(8'(i), 1'b1, 1'b0);
            if (i >= 4) check_flags("overrun_flags");
        end
        drain("overrun_pop");
    endtask

    task automatic test_framing();
        rx_frame(8'h55, 1'b0, 1'b0);
        check_flags("framing_flags");
        pop_and_check("framing_no_write");
        rx_frame(8'h55, 1'b1, 1'b0);
        check_flags("framing_recover_flags");
        drain("framing_recover");
        if (PAR_IDX >= 0) begin
            rx_frame(8'h07, 1'b1, 1'b1);
            check_flags("parity_flags");
            pop_and_check("parity_no_write");
        end
    endtask

    task automatic test_glitch();
        rxd_tb = 1'b0;
        rxd16  = 1'b0;
        step(1);
        rxd_tb = 1'b1;
        rxd16  = 1'b1;
        step(48);
        check_flags("glitch_flags");
        pop_and_check("glitch_no_write");
        checks++;
        if (rx_valid16 !== 1'b0 || fe16_cnt !== 0 || ovr16_cnt !== 0) begin
            errors++;
            $display("FAIL glitch_div16: rx_valid=%b fe=%0d ovr=%0d required 0/0/0",
                     rx_valid16, fe16_cnt, ovr16_cnt);
        end
    endtask

    task automatic test_random_rx();
        for (int i = 0; i < 10; i++) begin
            rx_frame(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
            check_flags("random_flags");
            if ($urandom_range(0, 1) == 1) pop_and_check("random_pop");
        end
        drain("random_drain");
    endtask

    initial begin
        reset      = 1'b1;
        rxd_tb     = 1'b1;
        loop_en    = 1'b0;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        rx_ready   = 1'b0;
        rxd16      = 1'b1;
        tx_data16  = 8'h00;
        tx_valid16 = 1'b0;
        rx_ready16 = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_loopback();
        test_overrun();
        test_framing();
        test_glitch();
        test_random_rx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
